// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control, data and status bundle of the universal shift register
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sl_in;
  logic             sr_in;
  logic             start;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;
  modport master (output mode, d, sl_in, sr_in, start, cnt, input q, sout_l, sout_r, busy, done);
  modport slave  (input mode, d, sl_in, sr_in, start, cnt, output q, sout_l, sout_r, busy, done);
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with a repeat-N burst engine
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic            clk,
  input logic            reset,
  univ_shift_reg_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_next;
  logic [CW-1:0]    r_rem;
  logic [2:0]       r_mode, w_op;
  logic             r_done, w_burst_mode, w_start_burst, w_zero;
  assign w_burst_mode  = bus.mode inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
  assign w_start_burst = r_state == IDLE && bus.start && w_burst_mode && bus.cnt != '0;
  assign w_zero        = r_state == IDLE && bus.start && w_burst_mode && bus.cnt == '0;
  assign w_op          = r_state == BUSY ? r_mode : bus.mode;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  // a burst of one finishes on its start edge and never enters BUSY
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == BUSY && r_rem == CW'(1)) w_state_nxt = IDLE;
    else if (w_start_burst && bus.cnt != CW'(1)) w_state_nxt = BUSY;
  end
  always_comb begin
    w_next = r_q;
    case (w_op)
      3'd1:    w_next = {r_q[WIDTH-2:0], bus.sl_in};
      3'd2:    w_next = {bus.sr_in, r_q[WIDTH-1:1]};
      3'd3:    w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      3'd4:    w_next = {r_q[0], r_q[WIDTH-1:1]};
      3'd5:    w_next = bus.d;
      3'd6:    w_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      3'd7:    w_next = '0;
      default: w_next = r_q;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= RST_VAL;
      r_rem  <= '0;
      r_mode <= '0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_zero ? r_q : w_next;
      r_done <= (r_state == BUSY && r_rem == CW'(1)) || w_zero || (w_start_burst && bus.cnt == CW'(1));
      if (r_state == BUSY) r_rem <= r_rem - CW'(1);
      else if (w_start_burst) begin
        r_rem  <= bus.cnt - CW'(1);
        r_mode <= bus.mode;
      end
    end
  end
  always_comb begin
    bus.q      = r_q;
    bus.sout_l = r_q[WIDTH-1];
    bus.sout_r = r_q[0];
    bus.busy   = r_state == BUSY;
    bus.done   = r_done;
  end
endmodule
